// File: rtl/decompose_stream_if.sv
// Stream bundle for decompose_stream: coefficient beats in, high/low parts out.
interface decompose_stream_if #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned COEFF_W = 24
);
    localparam int unsigned DW = LANES * COEFF_W;

    logic [2:0]    sec_lvl;
    logic          mode;
    logic          valid_i;
    logic          ready_i;
    logic [DW-1:0] di;
    logic [DW-1:0] doa;
    logic [DW-1:0] dob;
    logic          valid_o;
    logic          ready_o;
    logic          err_o;

    modport master (
        output sec_lvl, mode, valid_i, di, ready_o,
        input  ready_i, doa, dob, valid_o, err_o
    );

    modport slave (
        input  sec_lvl, mode, valid_i, di, ready_o,
        output ready_i, doa, dob, valid_o, err_o
    );
endinterface

// File: rtl/decompose_stream.sv
// Three-stage pipelined Decompose / Power2Round of LANES coefficients mod q,
// with a single global stall enable shared by every stage.
module decompose_stream #(
    parameter int unsigned LANES   = 4,
    parameter int unsigned COEFF_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    decompose_stream_if.slave bus
);
    localparam int unsigned RW          = 23;
    localparam int unsigned QW          = 11;
    localparam int unsigned Q_VAL       = 8380417;
    localparam int unsigned G2_NARROW   = 95232;
    localparam int unsigned G2_WIDE     = 261888;
    localparam int unsigned P2R_D       = 13;
    localparam int unsigned P2R_HALF    = 4096;
    localparam int unsigned WRAP_NARROW = (Q_VAL - 1) / (2 * G2_NARROW);
    localparam int unsigned WRAP_WIDE   = (Q_VAL - 1) / (2 * G2_WIDE);

    typedef struct packed {
        logic vld;
        logic err;
        logic mode;
        logic wide;
    } ctl_t;

    typedef logic [LANES-1:0][RW-1:0] lane_r_t;
    typedef logic [LANES-1:0][QW-1:0] lane_q_t;

    logic                     en_c;
    logic                     sec_wide_c;
    logic                     sec_bad_c;
    logic                     range_bad_c;

    ctl_t                     s1_ctl_q, s1_ctl_d;
    lane_r_t                  s1_r_q, s1_r_d;
    ctl_t                     s2_ctl_q, s2_ctl_d;
    lane_q_t                  s2_quo_q, s2_quo_d;
    lane_r_t                  s2_rem_q, s2_rem_d;
    logic                     s3_vld_q, s3_vld_d;
    logic                     s3_err_q, s3_err_d;
    logic [LANES*COEFF_W-1:0] s3_a_q, s3_a_d;
    logic [LANES*COEFF_W-1:0] s3_b_q, s3_b_d;

    // Every stage moves together unless the output beat is blocked downstream.
    assign en_c        = ~s3_vld_q | bus.ready_o;
    assign bus.ready_i = en_c & ~rst;
    assign bus.valid_o = s3_vld_q;
    assign bus.err_o   = s3_err_q;
    assign bus.doa     = s3_a_q;
    assign bus.dob     = s3_b_q;

    always_comb begin : input_decode
        sec_wide_c  = (bus.sec_lvl == 3'b011) || (bus.sec_lvl == 3'b101);
        sec_bad_c   = !(sec_wide_c || (bus.sec_lvl == 3'b010));
        range_bad_c = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (bus.di[k*COEFF_W +: COEFF_W] >= COEFF_W'(Q_VAL)) begin
                range_bad_c = 1'b1;
            end
        end
    end

    // Stage 1: capture the beat with its own mode/security qualifiers.
    always_comb begin : stage1_next
        s1_ctl_d = s1_ctl_q;
        s1_r_d   = s1_r_q;
        if (en_c) begin
            s1_ctl_d.vld  = bus.valid_i;
            s1_ctl_d.err  = sec_bad_c | range_bad_c;
            s1_ctl_d.mode = bus.mode;
            s1_ctl_d.wide = sec_wide_c;
            if (bus.valid_i) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    s1_r_d[k] = bus.di[k*COEFF_W +: RW];
                end
            end
        end
    end

    // Stage 2: floor quotient and non-negative remainder by the step size.
    always_comb begin : stage2_next
        s2_ctl_d = s2_ctl_q;
        s2_quo_d = s2_quo_q;
        s2_rem_d = s2_rem_q;
        if (en_c) begin
            s2_ctl_d = s1_ctl_q;
            for (int unsigned k = 0; k < LANES; k++) begin
                if (s1_ctl_q.mode) begin
                    s2_quo_d[k] = QW'(s1_r_q[k] >> P2R_D);
                    s2_rem_d[k] = RW'(s1_r_q[k][P2R_D-1:0]);
                end else if (s1_ctl_q.wide) begin
                    s2_quo_d[k] = QW'(s1_r_q[k] / RW'(2 * G2_WIDE));
                    s2_rem_d[k] = s1_r_q[k] % RW'(2 * G2_WIDE);
                end else begin
                    s2_quo_d[k] = QW'(s1_r_q[k] / RW'(2 * G2_NARROW));
                    s2_rem_d[k] = s1_r_q[k] % RW'(2 * G2_NARROW);
                end
            end
        end
    end

    // Stage 3: recentre the remainder, fold the top bucket to r1 = 0, reduce r0 mod q.
    always_comb begin : stage3_next
        logic [RW-1:0] half;
        logic [RW-1:0] alpha;
        logic [RW-1:0] lo;
        logic [QW-1:0] hi;
        logic [QW-1:0] wrap;

        s3_vld_d = s3_vld_q;
        s3_err_d = s3_err_q;
        s3_a_d   = s3_a_q;
        s3_b_d   = s3_b_q;
        hi       = '0;
        lo       = '0;

        if (s2_ctl_q.mode) begin
            half  = RW'(P2R_HALF);
            alpha = RW'(2 * P2R_HALF);
        end else if (s2_ctl_q.wide) begin
            half  = RW'(G2_WIDE);
            alpha = RW'(2 * G2_WIDE);
        end else begin
            half  = RW'(G2_NARROW);
            alpha = RW'(2 * G2_NARROW);
        end
        wrap = s2_ctl_q.wide ? QW'(WRAP_WIDE) : QW'(WRAP_NARROW);

        if (en_c) begin
            s3_vld_d = s2_ctl_q.vld;
            s3_err_d = s2_ctl_q.vld & s2_ctl_q.err;
            for (int unsigned k = 0; k < LANES; k++) begin
                if (s2_rem_q[k] > half) begin
                    hi = s2_quo_q[k] + QW'(1);
                    lo = s2_rem_q[k] + (RW'(Q_VAL) - alpha);
                end else begin
                    hi = s2_quo_q[k];
                    lo = s2_rem_q[k];
                end
                // r - r0' == q-1 lands exactly on bucket 'wrap'; that bucket folds back to zero.
                if (!s2_ctl_q.mode && (hi == wrap)) begin
                    hi = '0;
                    lo = (lo == '0) ? RW'(Q_VAL - 1) : lo - RW'(1);
                end
                if (s2_ctl_q.err) begin
                    hi = '0;
                    lo = '0;
                end
                s3_a_d[k*COEFF_W +: COEFF_W] = COEFF_W'(hi);
                s3_b_d[k*COEFF_W +: COEFF_W] = COEFF_W'(lo);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : stage_regs
        if (rst) begin
            s1_ctl_q <= '0;
            s1_r_q   <= '0;
            s2_ctl_q <= '0;
            s2_quo_q <= '0;
            s2_rem_q <= '0;
            s3_vld_q <= 1'b0;
            s3_err_q <= 1'b0;
            s3_a_q   <= '0;
            s3_b_q   <= '0;
        end else begin
            s1_ctl_q <= s1_ctl_d;
            s1_r_q   <= s1_r_d;
            s2_ctl_q <= s2_ctl_d;
            s2_quo_q <= s2_quo_d;
            s2_rem_q <= s2_rem_d;
            s3_vld_q <= s3_vld_d;
            s3_err_q <= s3_err_d;
            s3_a_q   <= s3_a_d;
            s3_b_q   <= s3_b_d;
        end
    end
endmodule

// File: tb/tb_decompose_stream.sv
// Self-checking bench for decompose_stream: directed vectors plus randomized
// streams scored against an arithmetic reference model.
module tb_decompose_stream;
    localparam int unsigned LANES   = 4;
    localparam int unsigned COEFF_W = 24;
    localparam int unsigned DW      = LANES * COEFF_W;
    localparam int          Q       = 8380417;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          err;
    } beat_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    int            n_cmp = 0;
    int            n_bad = 0;
    beat_exp_t     exp_q[$];
    bit            mon_stall = 1'b0;
    logic [DW-1:0] held_a;
    logic [DW-1:0] held_b;
    logic          held_err;

    always #5 clk = ~clk;

    decompose_stream_if #(.LANES(LANES), .COEFF_W(COEFF_W)) bus ();

    decompose_stream #(.LANES(LANES), .COEFF_W(COEFF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [DW-1:0] p;
        p = '0;
        p[0*COEFF_W +: COEFF_W] = COEFF_W'(l0);
        p[1*COEFF_W +: COEFF_W] = COEFF_W'(l1);
        p[2*COEFF_W +: COEFF_W] = COEFF_W'(l2);
        p[3*COEFF_W +: COEFF_W] = COEFF_W'(l3);
        return p;
    endfunction

    // Reference: centred reduction written straight from the algorithm definition.
    function automatic beat_exp_t model(input logic [DW-1:0] d, input logic [2:0] s, input logic m);
        beat_exp_t e;
        int        r, r0, r1, g, alpha;
        bit        bad;
        e.a = '0;
        e.b = '0;
        bad = !(s == 3'b010 || s == 3'b011 || s == 3'b101);
        for (int k = 0; k < LANES; k++) begin
            if (int'(d[k*COEFF_W +: COEFF_W]) >= Q) bad = 1'b1;
        end
        e.err = bad;
        if (!bad) begin
            for (int k = 0; k < LANES; k++) begin
                r = int'(d[k*COEFF_W +: COEFF_W]);
                if (m) begin
                    g     = 4096;
                    alpha = 8192;
                end else begin
                    g     = (s == 3'b010) ? 95232 : 261888;
                    alpha = 2 * g;
                end
                r0 = r % alpha;
                if (r0 > g) r0 = r0 - alpha;
                if (!m && (r - r0 == Q - 1)) begin
                    r1 = 0;
                    r0 = r0 - 1;
                end else begin
                    r1 = (r - r0) / alpha;
                end
                if (r0 < 0) r0 = r0 + Q;
                e.a[k*COEFF_W +: COEFF_W] = COEFF_W'(r1);
                e.b[k*COEFF_W +: COEFF_W] = COEFF_W'(r0);
            end
        end
        return e;
    endfunction

    function automatic logic [COEFF_W-1:0] rand_r();
        int bnd [17] = '{0, 1, 4095, 4096, 4097, 8192, 95232, 95233, 190464, 261888,
                         261889, 523776, 8285184, 8285185, 8118528, 8118529, 8380416};
        int p;
        p = $urandom_range(0, 39);
        if (p == 0) return COEFF_W'(Q + $urandom_range(0, 1000));
        if (p == 1) return '1;
        if (p < 10) return COEFF_W'(bnd[$urandom_range(0, 16)]);
        return COEFF_W'($urandom_range(0, Q - 1));
    endfunction

    function automatic logic [2:0] rand_sec();
        int p;
        p = $urandom_range(0, 15);
        if (p == 0) return 3'($urandom_range(0, 7));
        if (p < 6) return 3'b010;
        if (p < 11) return 3'b011;
        return 3'b101;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) d[k*COEFF_W +: COEFF_W] = rand_r();
        return d;
    endfunction

    // Scoreboard: predicts on every input handshake, checks on every output handshake.
    always @(negedge clk) begin
        beat_exp_t e;
        if (rst) begin
            exp_q.delete();
            mon_stall = 1'b0;
        end else begin
            check("ready_i_rule", DW'(bus.ready_i), DW'(!(bus.valid_o && !bus.ready_o)));
            if (mon_stall) begin
                check("stall_valid", DW'(bus.valid_o), DW'(1'b1));
                check("stall_doa", bus.doa, held_a);
                check("stall_dob", bus.dob, held_b);
                check("stall_err", DW'(bus.err_o), DW'(held_err));
            end
            if (bus.valid_o && bus.ready_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", DW'(bus.valid_o), '0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_doa", bus.doa, e.a);
                    check("stream_dob", bus.dob, e.b);
                    check("stream_err", DW'(bus.err_o), DW'(e.err));
                end
            end
            if (bus.valid_i && bus.ready_i) exp_q.push_back(model(bus.di, bus.sec_lvl, bus.mode));
            mon_stall = bus.valid_o && !bus.ready_o;
            held_a    = bus.doa;
            held_b    = bus.dob;
            held_err  = bus.err_o;
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic [2:0] s, input logic m, input bit rnd_rdy);
        bit acc;
        acc         = 1'b0;
        bus.di      = d;
        bus.sec_lvl = s;
        bus.mode    = m;
        bus.valid_i = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            acc = bus.ready_i;
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.ready_o = 1'($urandom_range(0, 1));
            if (acc) return;
        end
        check("accept_timeout", DW'(acc), DW'(1'b1));
    endtask

    task automatic idle(input int n, input bit rnd_rdy);
        bus.valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.ready_o = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        bus.valid_i = 1'b0;
        bus.ready_o = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.valid_o) break;
        end
        check("drain_left", DW'(exp_q.size()), '0);
    endtask

    // Single beat into an empty pipe with ready_o high; checks latency and fixed results.
    task automatic send_one(input string tag, input logic [DW-1:0] d, input logic [2:0] s, input logic m,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic ee);
        bus.ready_o = 1'b1;
        send_beat(d, s, m, 1'b0);
        bus.valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_lat1"}, DW'(bus.valid_o), '0);
        @(negedge clk);
        check({tag, "_lat2"}, DW'(bus.valid_o), '0);
        @(negedge clk);
        check({tag, "_valid"}, DW'(bus.valid_o), DW'(1'b1));
        check({tag, "_doa"}, bus.doa, ea);
        check({tag, "_dob"}, bus.dob, eb);
        check({tag, "_err"}, DW'(bus.err_o), DW'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.di      = '0;
        bus.sec_lvl = 3'b010;
        bus.mode    = 1'b0;
        bus.ready_o = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", DW'(bus.valid_o), '0);
        check("rst_err_o", DW'(bus.err_o), '0);
        check("rst_doa", bus.doa, '0);
        check("rst_dob", bus.dob, '0);
        check("rst_ready_i", DW'(bus.ready_i), '0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", DW'(bus.ready_i), DW'(1'b1));

        send_one("dec_l2", pack4(0, 95232, 95233, 8380416), 3'b010, 1'b0,
                 pack4(0, 0, 1, 0), pack4(0, 95232, 8285186, 8380416), 1'b0);
        send_one("dec_l3", pack4(1000000, 1000000, 1000000, 1000000), 3'b011, 1'b0,
                 pack4(2, 2, 2, 2), pack4(8332865, 8332865, 8332865, 8332865), 1'b0);
        send_one("p2r", pack4(4096, 4097, 8380416, 0), 3'b010, 1'b1,
                 pack4(0, 1, 1023, 0), pack4(4096, 8376322, 0, 0), 1'b0);
        send_one("bad_sec", pack4(5, 6, 7, 8), 3'b000, 1'b0, '0, '0, 1'b1);
        send_one("bad_range", pack4(5, Q, 7, 8), 3'b010, 1'b0, '0, '0, 1'b1);

        // Erroneous beats sandwiched between good ones, back to back.
        send_beat(pack4(95233, 1, 2, 3), 3'b010, 1'b0, 1'b0);
        send_beat(pack4(5, 6, 7, 8), 3'b000, 1'b0, 1'b0);
        send_beat(pack4(5, Q, 7, 8), 3'b101, 1'b1, 1'b0);
        send_beat(pack4(8118529, 261889, 4097, 8380416), 3'b101, 1'b0, 1'b0);
        drain();

        // Back-to-back stream with random downstream backpressure.
        for (int i = 0; i < 24; i++) send_beat(rand_beat(), rand_sec(), 1'($urandom_range(0, 1)), 1'b1);
        drain();

        // Stream with random bubbles and backpressure.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), 1'b1);
            send_beat(rand_beat(), rand_sec(), 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        // Reset with three beats in flight and the output stalled.
        bus.ready_o = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(rand_beat(), 3'b011, 1'b0, 1'b0);
        bus.valid_i = 1'b0;
        check("inflight_valid", DW'(bus.valid_o), DW'(1'b1));
        check("inflight_ready_i", DW'(bus.ready_i), '0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid_o", DW'(bus.valid_o), '0);
        check("mid_rst_doa", bus.doa, '0);
        check("mid_rst_dob", bus.dob, '0);
        check("mid_rst_err_o", DW'(bus.err_o), '0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.ready_o = 1'b1;
        #1;
        check("ready_after_rst2", DW'(bus.ready_i), DW'(1'b1));
        repeat (6) begin
            @(negedge clk);
            check("no_stale", DW'(bus.valid_o), '0);
        end
        @(posedge clk);
        #1;
        send_one("post_rst", pack4(523776, 523777, 261888, 261889), 3'b101, 1'b0,
                 pack4(1, 1, 0, 1), pack4(0, 1, 261888, 8118530), 1'b0);
        for (int i = 0; i < 12; i++) send_beat(rand_beat(), rand_sec(), 1'($urandom_range(0, 1)), 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/decompose_stream.md
DECOMPOSE_STREAM -- requirements
Module: decompose_stream

Interface
REQ-001 SHALL have parameter LANES, default 4, coefficients per beat (1..8).
REQ-002 SHALL have parameter COEFF_W, default 24, bits per coefficient (>=23).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sec_lvl  input  3  security level of the input beat: 3'b010, 3'b011 or 3'b101 valid.
REQ-006 SHALL have port mode  input  1  0 = Decompose, 1 = Power2Round (d=13).
REQ-007 SHALL have port valid_i  input  1  upstream beat valid.
REQ-008 SHALL have port ready_i  output  1  block can accept a beat.
REQ-009 SHALL have port di  input  LANES*COEFF_W  coefficients r, lane k at bits [k*COEFF_W +: COEFF_W].
REQ-010 SHALL have port doa  output  LANES*COEFF_W  high parts r1, same lane packing, zero-extended.
REQ-011 SHALL have port dob  output  LANES*COEFF_W  low parts r0, same lane packing, as r0 mod q in [0,q).
REQ-012 SHALL have port valid_o  output  1  output beat valid.
REQ-013 SHALL have port ready_o  input  1  downstream accepts beat.
REQ-014 SHALL have port err_o  output  1  qualifies current output beat as erroneous; meaningful only with valid_o.

Function
REQ-015 q = 8380417; gamma2 = 95232 for sec_lvl 3'b010, 261888 for 3'b011 and 3'b101.
REQ-016 Decompose per lane: r0' = r mod+- 2*gamma2 in (-gamma2, gamma2]; if r - r0' = q-1 then r1 = 0, r0 = r0'-1; else r1 = (r - r0')/(2*gamma2), r0 = r0'.
REQ-017 Power2Round per lane: r0 = r mod+- 8192 in (-4096, 4096], r1 = (r - r0)/8192; sec_lvl ignored for range but still checked by REQ-018.
REQ-018 Beat erroneous if sec_lvl not in {010,011,101} or any lane r >= q; erroneous beat SHALL emit doa = dob = 0 and err_o = 1; otherwise err_o = 0.
REQ-019 sec_lvl and mode SHALL be sampled with the beat at acceptance and travel with it; changes affect only later beats.
REQ-020 Beat accepted on rising edge where valid_i & ready_i.
REQ-021 Pipeline of exactly 3 register stages; unstalled latency 3 cycles from accept edge to valid_o high.
REQ-022 Global advance enable en = ~valid_o | ready_o; ready_i SHALL equal en (combinational), forced 0 while rst high.
REQ-023 Throughput one beat per cycle while ready_o held high; no bubble insertion, no beat loss, no duplication.
REQ-024 While valid_o & ~ready_o, all stages SHALL hold; doa, dob, err_o, valid_o stable until handshake.
REQ-025 Accept edge with valid_i & ready_i while output handshake completes SHALL both shift and capture in same cycle.
REQ-026 Bubbles (valid_i low) SHALL propagate as invalid stage slots; valid_o low for those slots.
REQ-027 Output order SHALL equal input order; all lanes of one beat appear together.

Reset
REQ-028 rst high SHALL asynchronously clear all stage valids, valid_o = 0, err_o = 0, doa = 0, dob = 0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; first beat accepted after rst release exits after 3 cycles.
REQ-030 ready_i SHALL be 1 in the first cycle after rst deasserts (pipeline empty).

Verification
REQ-031 sec_lvl=010, mode=0, lanes r={0, 95232, 95233, 8380416}, ready_o=1 -> 3 cycles later doa={0,0,1,0}, dob={0,95232,8285186,8380416}, err_o=0.
REQ-032 sec_lvl=011, mode=0, r=1000000 all lanes -> doa lanes=2, dob lanes=8332865.
REQ-033 mode=1, r={4096, 4097, 8380416, 0} -> doa={0,1,1023,0}, dob={4096,8376322,0,0}.
REQ-034 Stream 16 back-to-back beats, ready_o toggled pseudo-randomly -> outputs match model in order, held stable during stalls, ready_i low exactly when valid_o & ~ready_o.
REQ-035 Beat with sec_lvl=000, then beat with one lane r=8380417 -> both emit doa=dob=0, err_o=1; neighbouring valid beats unaffected.
REQ-036 rst asserted with 3 beats in flight and ready_o=0 -> valid_o falls immediately, outputs 0; no stale beat appears after release.
